// File: rtl/sprite_mover.sv
// Per-frame sprite motion controller: moves X/Y by a signed velocity on each enabled vsync
// rising edge and writes the result to sprite RAM entries 8/9. Define SPRITE_MOVER_WRAP_EN for wrap mode.
module sprite_mover #(
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 248,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 120,
  parameter int X_INIT  = 0,
  parameter int Y_INIT  = 0,
  parameter int VX_INIT = 1,
  parameter int VY_INIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       enable,
  input  logic       cmd_we,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [3:0] cmd_vx,
  input  logic [3:0] cmd_vy,
  output logic       we,
  output logic [3:0] address,
  output logic [7:0] data,
  output logic       busy,
  output logic       hit_x,
  output logic       hit_y
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WR_X, S_WR_Y} state_t;

  localparam logic [7:0]        XLO   = 8'(X_MIN);
  localparam logic [7:0]        XHI   = 8'(X_MAX);
  localparam logic [7:0]        YLO   = 8'(Y_MIN);
  localparam logic [7:0]        YHI   = 8'(Y_MAX);
  localparam logic signed [9:0] XLO_S = 10'(X_MIN);
  localparam logic signed [9:0] XHI_S = 10'(X_MAX);
  localparam logic signed [9:0] YLO_S = 10'(Y_MIN);
  localparam logic signed [9:0] YHI_S = 10'(Y_MAX);

  state_t      r_state, w_next;
  logic        r_vsync_q, w_vs_rise;
  logic [7:0]  r_x, r_y, r_px, r_py;
  logic [3:0]  r_vx, r_vy, r_pvx, r_pvy;
  logic        r_pend, w_apply;
  logic        r_we, r_hit_x, r_hit_y;
  logic [3:0]  r_addr;
  logic [7:0]  r_data;
  logic [12:0] w_sx, w_sy;

  // -8 has no positive counterpart in 4 bits, so it saturates to +7
  function automatic logic [3:0] f_neg(input logic [3:0] v);
    f_neg = (v == 4'b1000) ? 4'b0111 : 4'(-v);
  endfunction

  // Returns {hit, new_velocity, new_position}
  function automatic logic [12:0] f_step(input logic [7:0] p, input logic [3:0] v,
                                         input logic signed [9:0] lo, input logic signed [9:0] hi);
    logic signed [9:0] n;
    n = $signed({2'b00, p}) + $signed({{6{v[3]}}, v});
`ifdef SPRITE_MOVER_WRAP_EN
    if (n > hi)      f_step = {1'b1, v, 8'(lo + (n - hi - 10'sd1))};
    else if (n < lo) f_step = {1'b1, v, 8'(hi - (lo - n - 10'sd1))};
`else
    if (n > hi)      f_step = {1'b1, f_neg(v), hi[7:0]};
    else if (n < lo) f_step = {1'b1, f_neg(v), lo[7:0]};
`endif
    else             f_step = {1'b0, v, n[7:0]};
  endfunction

  function automatic logic [7:0] f_clamp(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] hi);
    f_clamp = (c > hi) ? hi : ((c < lo) ? lo : c);
  endfunction

  assign w_vs_rise = vsync & ~r_vsync_q;
  assign w_apply   = (r_state == S_IDLE) && (cmd_we || r_pend);
  assign w_sx      = f_step(r_x, r_vx, XLO_S, XHI_S);
  assign w_sy      = f_step(r_y, r_vy, YLO_S, YHI_S);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_vs_rise && enable) w_next = S_CALC;
      S_CALC: w_next = S_WR_X;
      S_WR_X: w_next = S_WR_Y;
      S_WR_Y: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // A live cmd_we in IDLE bypasses the buffer so it lands on the same edge it arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsync_q <= 1'b0;
      r_x       <= 8'(X_INIT);
      r_y       <= 8'(Y_INIT);
      r_vx      <= 4'(VX_INIT);
      r_vy      <= 4'(VY_INIT);
      r_pend    <= 1'b0;
      r_px      <= '0;
      r_py      <= '0;
      r_pvx     <= '0;
      r_pvy     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_hit_x   <= 1'b0;
      r_hit_y   <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_we      <= (r_state == S_CALC) || (r_state == S_WR_X);
      r_hit_x   <= (r_state == S_CALC) && w_sx[12];
      r_hit_y   <= (r_state == S_CALC) && w_sy[12];
      if (w_apply) begin
        r_x    <= f_clamp(cmd_we ? cmd_x : r_px, XLO, XHI);
        r_y    <= f_clamp(cmd_we ? cmd_y : r_py, YLO, YHI);
        r_vx   <= cmd_we ? cmd_vx : r_pvx;
        r_vy   <= cmd_we ? cmd_vy : r_pvy;
        r_pend <= 1'b0;
      end else if (cmd_we) begin
        r_px   <= cmd_x;
        r_py   <= cmd_y;
        r_pvx  <= cmd_vx;
        r_pvy  <= cmd_vy;
        r_pend <= 1'b1;
      end
      if (r_state == S_CALC) begin
        r_x    <= w_sx[7:0];
        r_vx   <= w_sx[11:8];
        r_y    <= w_sy[7:0];
        r_vy   <= w_sy[11:8];
        r_addr <= 4'd8;
        r_data <= w_sx[7:0];
      end else if (r_state == S_WR_X) begin
        r_addr <= 4'd9;
        r_data <= r_y;
      end
    end
  end

  assign we      = r_we;
  assign address = r_addr;
  assign data    = r_data;
  assign hit_x   = r_hit_x;
  assign hit_y   = r_hit_y;

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Per-frame motion controller that sits directly upstream of the 8x8 sprite renderer and drives its sprite-RAM write port.
- On each rising edge of vsync it advances the sprite X/Y position by a signed velocity and bounces off the configured playfield limits.
- It then writes the new X byte to sprite RAM entry 8 and the new Y byte to entry 9, one write per cycle.
- The CPU/test logic can load position and velocity through a one-shot command port.

Parameters:
- X_MIN, 0, lowest legal X
- X_MAX, 248, highest legal X (256-8)
- Y_MIN, 0, lowest legal Y
- Y_MAX, 120, highest legal Y (128-8)
- X_INIT, 0, X after reset
- Y_INIT, 0, Y after reset
- VX_INIT, 1, X velocity after reset (4-bit two's complement)
- VY_INIT, 1, Y velocity after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- vsync  in  1  vertical sync from the sync generator; level input, edge-detected internally
- enable  in  1  1 = respond to vsync rising edges
- cmd_we  in  1  one-cycle strobe: load cmd_x/cmd_y/cmd_vx/cmd_vy
- cmd_x  in  8  position X to load
- cmd_y  in  8  position Y to load
- cmd_vx  in  4  signed X velocity to load
- cmd_vy  in  4  signed Y velocity to load
- we  out  1  sprite RAM write enable (registered)
- address  out  4  sprite RAM entry index (registered)
- data  out  8  sprite RAM write byte (registered)
- busy  out  1  1 while in CALC/WR_X/WR_Y
- hit_x  out  1  one-cycle pulse when X hit a limit this frame
- hit_y  out  1  one-cycle pulse when Y hit a limit this frame

Behaviour:
- Reset values: x=X_INIT, y=Y_INIT, vx=VX_INIT, vy=VY_INIT, vsync_q=0, state=IDLE, pending=0; outputs we=0, address=0, data=0, busy=0, hit_x=0, hit_y=0.
- Edge detect: vs_rise = vsync & ~vsync_q; vsync_q <= vsync every cycle.
- States:
  - IDLE -> CALC at the edge where vs_rise & enable.
  - CALC -> WR_X -> WR_Y -> IDLE, unconditionally, one cycle each.
- Timing for a vs_rise sampled at edge E:
  - E+1: x/y/vx/vy updated; we=1, address=8, data=new x; hit_x/hit_y valid for this cycle only.
  - E+2: we=1, address=9, data=new y; hits=0.
  - E+3: we=0, address and data hold last values.
  - busy=1 from E to E+3 exclusive.
- CALC arithmetic:
  - 10-bit signed: nx = zero-ext x + sign-ext vx.
  - If nx > X_MAX: x=X_MAX, vx=-vx, hit_x=1.
  - Else if nx < X_MIN: x=X_MIN, vx=-vx, hit_x=1.
  - Otherwise x=nx[7:0].
  - Y is identical, using Y_MIN/Y_MAX/vy/hit_y.
  - Negating -8 saturates to +7.
  - Zero velocity never hits.
- Command port:
  - cmd_we captures all four cmd values into a one-deep pending buffer.
  - The buffer is applied at the first edge where state=IDLE, including the same edge as cmd_we when already IDLE.
  - A second cmd_we before application overwrites the buffer (last wins).
  - cmd_x/cmd_y are clamped into [MIN,MAX] on application; no hit pulse.
- Simultaneous cmd application and vs_rise in IDLE: the command is applied at that edge and the following CALC uses the loaded values.
- vs_rise while busy, or while enable=0: ignored, not queued.
- enable falling mid-sequence: the sequence completes.
- reset asserted mid-sequence: all state and outputs go to reset values immediately, regardless of clk; a write in flight is dropped.

Optional Feature:
- Macro: SPRITE_MOVER_WRAP_EN.
- Defined, wrap mode replaces bounce:
  - nx > X_MAX gives x = X_MIN + (nx - X_MAX - 1).
  - nx < X_MIN gives x = X_MAX - (X_MIN - nx - 1).
  - Velocity is unchanged; hit_x still pulses.
  - Y is identical.
- Undefined: bounce/clamp behaviour as above. No port or timing differences.

Test Plan:
- Reset, enable=1, vsync 0->1 at edge E -> E+1 we=1 addr=8 data=1; E+2 we=1 addr=9 data=1; E+3 we=0; busy high E..E+2.
- cmd x=247 y=60 vx=+3 vy=0, then vsync pulse -> data 248 then 60, hit_x=1 at E+1, vx=-3; next vsync -> x=245, hit_x=0.
- cmd x=1 vx=-8 vy=-1 y=0, vsync -> x=0, vx=+7, y=0, vy=+1, hit_x=hit_y=1; next vsync -> x=7, y=1.
- cmd_we (x=100) during WR_X -> that frame writes the old position; x=100 is applied at the return to IDLE; next vsync writes 100+vx.
- Assert reset during WR_X -> we=0 immediately, x=X_INIT; a vsync pulse while enable=0 -> no writes, busy stays 0.
- With SPRITE_MOVER_WRAP_EN: x=247 vx=+3 -> x=1, vx stays +3, hit_x=1; x=1 vx=-3 -> x=247.
